traffic_phase_controller: RTL and testbench

//  Sequences a PIFO testbench run through warmup, measurement and drain phases.

---
 rtl/traffic_phase_controller.sv | 156 +++++++++++++++
 tb/tb_traffic_phase_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// Warmup/measure/drain run sequencer with PIFO occupancy tracking.
// Optional measurement statistics enabled by defining TRAFFIC_PHASE_STATS_EN.
module traffic_phase_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i__start,
    input  logic [CNT_W-1:0] i__warmup_cycles,
    input  logic [CNT_W-1:0] i__measure_cycles,
    input  logic [CNT_W-1:0] i__drain_timeout,
    input  logic             i__enq_fire,
    input  logic             i__deq_fire,
    output logic             o__inject_phase,
    output logic             o__receive_phase,
    output logic             o__measure,
    output logic [CNT_W-1:0] o__phase_count,
    output logic [CNT_W-1:0] o__occupancy,
    output logic             o__done,
    output logic             o__timeout
`ifdef TRAFFIC_PHASE_STATS_EN
   ,output logic [CNT_W-1:0] o__meas_enq_count,
    output logic [CNT_W-1:0] o__meas_deq_count,
    output logic             o__underflow
`endif
);

    typedef enum logic [2:0] {IDLE, WARMUP, MEASURE, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] warmup_len;
    logic [CNT_W-1:0] measure_len;
    logic [CNT_W-1:0] drain_timeout;
    logic [CNT_W-1:0] occ_next;
    logic [CNT_W-1:0] count_inc;
    logic             start_accept;

    assign start_accept = i__start && (state == IDLE || state == DONE);
    assign count_inc    = (o__phase_count == CNT_MAX) ? o__phase_count : o__phase_count + ONE;

    always_comb begin
        occ_next = o__occupancy;
        if (i__enq_fire && !i__deq_fire && o__occupancy != CNT_MAX)
            occ_next = o__occupancy + ONE;
        else if (!i__enq_fire && i__deq_fire && o__occupancy != '0)
            occ_next = o__occupancy - ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            warmup_len       <= '0;
            measure_len      <= '0;
            drain_timeout    <= '0;
            o__inject_phase  <= 1'b0;
            o__receive_phase <= 1'b0;
            o__measure       <= 1'b0;
            o__phase_count   <= '0;
            o__occupancy     <= '0;
            o__done          <= 1'b0;
            o__timeout       <= 1'b0;
        end else begin
            o__occupancy <= occ_next;
            case (state)
                IDLE, DONE: begin
                    if (i__start) begin
                        warmup_len     <= i__warmup_cycles;
                        measure_len    <= i__measure_cycles;
                        drain_timeout  <= i__drain_timeout;
                        o__occupancy   <= '0;
                        o__done        <= 1'b0;
                        o__timeout     <= 1'b0;
                        o__phase_count <= '0;
                        o__receive_phase <= 1'b1;
                        // Skip zero-length phases so the run begins in the first real one.
                        if (i__warmup_cycles != '0) begin
                            state           <= WARMUP;
                            o__inject_phase <= 1'b1;
                        end else if (i__measure_cycles != '0) begin
                            state           <= MEASURE;
                            o__inject_phase <= 1'b1;
                            o__measure      <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                WARMUP: begin
                    if (o__phase_count == warmup_len - ONE) begin
                        o__phase_count <= '0;
                        if (measure_len != '0) begin
                            state      <= MEASURE;
                            o__measure <= 1'b1;
                        end else begin
                            state           <= DRAIN;
                            o__inject_phase <= 1'b0;
                        end
                    end else begin
                        o__phase_count <= count_inc;
                    end
                end
                MEASURE: begin
                    if (o__phase_count == measure_len - ONE) begin
                        state           <= DRAIN;
                        o__phase_count  <= '0;
                        o__inject_phase <= 1'b0;
                        o__measure      <= 1'b0;
                    end else begin
                        o__phase_count <= count_inc;
                    end
                end
                DRAIN: begin
                    // Empty check has priority over the timeout; phase_count is left as the final value.
                    if (o__occupancy == '0) begin
                        state            <= DONE;
                        o__receive_phase <= 1'b0;
                        o__done          <= 1'b1;
                        o__timeout       <= 1'b0;
                    end else if (drain_timeout != '0 && o__phase_count == drain_timeout - ONE) begin
                        state            <= DONE;
                        o__receive_phase <= 1'b0;
                        o__done          <= 1'b1;
                        o__timeout       <= 1'b1;
                    end else begin
                        o__phase_count <= count_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRAFFIC_PHASE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            o__meas_enq_count <= '0;
            o__meas_deq_count <= '0;
            o__underflow      <= 1'b0;
        end else begin
            if (o__measure && i__enq_fire && o__meas_enq_count != CNT_MAX)
                o__meas_enq_count <= o__meas_enq_count + ONE;
            if (o__measure && i__deq_fire && o__meas_deq_count != CNT_MAX)
                o__meas_deq_count <= o__meas_deq_count + ONE;
            if (i__deq_fire && !i__enq_fire && o__occupancy == '0)
                o__underflow <= 1'b1;
        end
    end
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller against a run-timeline reference model.
// Statistics outputs are checked when TRAFFIC_PHASE_STATS_EN is defined.
module tb_traffic_phase_controller;

    localparam longint OCC_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_w = '0, cfg_m = '0, cfg_t = '0;
    logic        enq = 1'b0, deq = 1'b0;
    logic        inject, receive, measure, done, timeout;
    logic [31:0] phase_count, occupancy;
    logic [4:0]  flags;
`ifdef TRAFFIC_PHASE_STATS_EN
    logic [31:0] meas_enq, meas_deq;
    logic        underflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a run is a timeline indexed by cycles since start (k = 1 is the first phase cycle).
    bit     m_active = 0, m_done = 0, m_to = 0, m_uf = 0;
    longint m_k = 0, m_w = 0, m_m = 0, m_t = 0, m_hold = 0, m_occ = 0, m_eq = 0, m_dq = 0;
    logic [4:0]  e_flags = '0;
    logic [31:0] e_pc = '0, e_occ = '0;

    traffic_phase_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .i__start(start),
        .i__warmup_cycles(cfg_w), .i__measure_cycles(cfg_m), .i__drain_timeout(cfg_t),
        .i__enq_fire(enq), .i__deq_fire(deq),
        .o__inject_phase(inject), .o__receive_phase(receive), .o__measure(measure),
        .o__phase_count(phase_count), .o__occupancy(occupancy),
        .o__done(done), .o__timeout(timeout)
`ifdef TRAFFIC_PHASE_STATS_EN
       ,.o__meas_enq_count(meas_enq), .o__meas_deq_count(meas_deq), .o__underflow(underflow)
`endif
    );

    assign flags = {inject, receive, measure, done, timeout};

    always #5 clk = ~clk;

    task automatic tick(input logic st, input logic en, input logic de, input logic rs);
        bit     cur_meas;
        longint cur_occ, d;
        start = st; enq = en; deq = de; reset = rs;
        cur_meas = e_flags[2];
        cur_occ  = m_occ;
        if (rs) begin
            m_active = 0; m_done = 0; m_to = 0; m_uf = 0;
            m_k = 0; m_hold = 0; m_occ = 0; m_eq = 0; m_dq = 0;
        end else if (st && !m_active) begin
            m_w = longint'(cfg_w); m_m = longint'(cfg_m); m_t = longint'(cfg_t);
            m_active = 1; m_k = 1; m_done = 0; m_to = 0;
            m_occ = 0; m_eq = 0; m_dq = 0; m_uf = 0;
        end else begin
            if (cur_meas && en && m_eq < OCC_MAX) m_eq++;
            if (cur_meas && de && m_dq < OCC_MAX) m_dq++;
            if (de && !en && cur_occ == 0) m_uf = 1;
            if (en && !de && m_occ < OCC_MAX) m_occ++;
            else if (de && !en && m_occ > 0) m_occ--;
            if (m_active) begin
                if (m_k > m_w + m_m) begin
                    d = m_k - m_w - m_m - 1;
                    if (cur_occ == 0) begin
                        m_active = 0; m_done = 1; m_to = 0; m_hold = d;
                    end else if (m_t != 0 && d == m_t - 1) begin
                        m_active = 0; m_done = 1; m_to = 1; m_hold = d;
                    end else m_k++;
                end else m_k++;
            end
        end
        @(posedge clk);
        #1;
        if (m_active) begin
            if (m_k <= m_w) begin
                e_flags = 5'b11000; e_pc = 32'(m_k - 1);
            end else if (m_k <= m_w + m_m) begin
                e_flags = 5'b11100; e_pc = 32'(m_k - m_w - 1);
            end else begin
                e_flags = 5'b01000; e_pc = 32'(m_k - m_w - m_m - 1);
            end
        end else begin
            e_flags = {3'b000, m_done, m_to};
            e_pc    = 32'(m_hold);
        end
        e_occ = 32'(m_occ);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 1);
            checks += 3;
            if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags got %b exp 00000", flags); end
            if (phase_count !== 32'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", phase_count); end
            if (occupancy !== 32'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_basic_run();
        int n_inj = 0, n_meas = 0;
        cfg_w = 4; cfg_m = 8; cfg_t = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 60 && done !== 1'b1; i++) begin
            n_inj  += int'(inject);
            n_meas += int'(measure);
            if (i < 12) tick(0, 1, i >= 1, 0);
            else        tick(0, 0, 1, 0);
            checks += 3;
            if (flags !== e_flags) begin errors++; $display("FAIL basic_flags got %b exp %b", flags, e_flags); end
            if (phase_count !== e_pc) begin errors++; $display("FAIL basic_pc got %0d exp %0d", phase_count, e_pc); end
            if (occupancy !== e_occ) begin errors++; $display("FAIL basic_occ got %0d exp %0d", occupancy, e_occ); end
        end
        checks += 3;
        if (n_inj !== 12) begin errors++; $display("FAIL basic_inject_cycles got %0d exp 12", n_inj); end
        if (n_meas !== 8) begin errors++; $display("FAIL basic_measure_cycles got %0d exp 8", n_meas); end
        if ({done, timeout} !== 2'b10) begin errors++; $display("FAIL basic_end got %b exp 10", {done, timeout}); end
    endtask

    task automatic test_zero_phases();
        cfg_w = 0; cfg_m = 0; cfg_t = 0;
        tick(1, 0, 0, 0);
        checks += 2;
        if (flags !== 5'b01000) begin errors++; $display("FAIL zero_drain_flags got %b exp 01000", flags); end
        if (flags !== e_flags) begin errors++; $display("FAIL zero_model_flags got %b exp %b", flags, e_flags); end
        tick(0, 0, 0, 0);
        checks += 2;
        if (flags !== 5'b00010) begin errors++; $display("FAIL zero_done_flags got %b exp 00010", flags); end
        if (phase_count !== e_pc) begin errors++; $display("FAIL zero_pc got %0d exp %0d", phase_count, e_pc); end
    endtask

    task automatic test_drain_timeout();
        int n_drain = 0;
        cfg_w = 3; cfg_m = 0; cfg_t = 5;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        for (int i = 0; i < 30 && done !== 1'b1; i++) begin
            n_drain += int'(receive && !inject);
            tick(0, 0, 0, 0);
            checks += 3;
            if (flags !== e_flags) begin errors++; $display("FAIL tmo_flags got %b exp %b", flags, e_flags); end
            if (phase_count !== e_pc) begin errors++; $display("FAIL tmo_pc got %0d exp %0d", phase_count, e_pc); end
            if (occupancy !== 32'd3) begin errors++; $display("FAIL tmo_occ got %0d exp 3", occupancy); end
        end
        checks += 2;
        if (n_drain !== 5) begin errors++; $display("FAIL tmo_drain_cycles got %0d exp 5", n_drain); end
        if ({done, timeout} !== 2'b11) begin errors++; $display("FAIL tmo_end got %b exp 11", {done, timeout}); end
    endtask

    task automatic test_occupancy();
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1, 0);
            checks++;
            if (occupancy !== 32'd3) begin errors++; $display("FAIL occ_hold got %0d exp 3", occupancy); end
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 1, 0);
            checks++;
            if (occupancy !== e_occ) begin errors++; $display("FAIL occ_underflow got %0d exp %0d", occupancy, e_occ); end
        end
`ifdef TRAFFIC_PHASE_STATS_EN
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL occ_underflow_flag got %b exp 1", underflow); end
`endif
    endtask

    task automatic test_mid_reset();
        cfg_w = 2; cfg_m = 6; cfg_t = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        checks += 2;
        if (flags !== 5'b11100) begin errors++; $display("FAIL mrst_in_measure got %b exp 11100", flags); end
        if (phase_count !== 32'd3) begin errors++; $display("FAIL mrst_pc got %0d exp 3", phase_count); end
        tick(0, 1, 0, 1);
        checks += 3;
        if (flags !== 5'b00000) begin errors++; $display("FAIL mrst_flags got %b exp 00000", flags); end
        if (phase_count !== 32'd0) begin errors++; $display("FAIL mrst_pc0 got %0d exp 0", phase_count); end
        if (occupancy !== 32'd0) begin errors++; $display("FAIL mrst_occ got %0d exp 0", occupancy); end
        tick(1, 0, 0, 0);
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            tick(0, i < 8, i >= 8, 0);
            checks += 3;
            if (flags !== e_flags) begin errors++; $display("FAIL mrst_run_flags got %b exp %b", flags, e_flags); end
            if (phase_count !== e_pc) begin errors++; $display("FAIL mrst_run_pc got %0d exp %0d", phase_count, e_pc); end
            if (occupancy !== e_occ) begin errors++; $display("FAIL mrst_run_occ got %0d exp %0d", occupancy, e_occ); end
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL mrst_run_done got %b exp 1", done); end
    endtask

    task automatic test_ignore_start();
        int n_inj = 0, n_meas = 0;
        cfg_w = 3; cfg_m = 2; cfg_t = 0;
        tick(1, 0, 0, 0);
        cfg_w = 9; cfg_m = 9; cfg_t = 9;
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            n_inj  += int'(inject);
            n_meas += int'(measure);
            tick(i == 1, 0, 0, 0);
            checks += 2;
            if (flags !== e_flags) begin errors++; $display("FAIL ign_flags got %b exp %b", flags, e_flags); end
            if (phase_count !== e_pc) begin errors++; $display("FAIL ign_pc got %0d exp %0d", phase_count, e_pc); end
        end
        checks += 2;
        if (n_inj !== 5) begin errors++; $display("FAIL ign_inject_cycles got %0d exp 5", n_inj); end
        if (n_meas !== 2) begin errors++; $display("FAIL ign_measure_cycles got %0d exp 2", n_meas); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (!inject) begin
                cfg_w = $urandom_range(0, 6); cfg_m = $urandom_range(0, 6); cfg_t = $urandom_range(0, 6);
            end
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 299) == 0);
            checks += 3;
            if (flags !== e_flags) begin errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", i, flags, e_flags); end
            if (phase_count !== e_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %0d exp %0d", i, phase_count, e_pc); end
            if (occupancy !== e_occ) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d exp %0d", i, occupancy, e_occ); end
`ifdef TRAFFIC_PHASE_STATS_EN
            checks += 3;
            if (meas_enq !== 32'(m_eq)) begin errors++; $display("FAIL rnd_meas_enq got %0d exp %0d", meas_enq, m_eq); end
            if (meas_deq !== 32'(m_dq)) begin errors++; $display("FAIL rnd_meas_deq got %0d exp %0d", meas_deq, m_dq); end
            if (underflow !== m_uf) begin errors++; $display("FAIL rnd_underflow got %b exp %b", underflow, m_uf); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_zero_phases();
        test_drain_timeout();
        test_occupancy();
        test_mid_reset();
        test_ignore_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
